// File: rtl/tmds_decoder.sv
// tmds_decoder
// Receive-side TMDS channel decoder. It recovers the 10-bit word boundary
// from a free-running deserializer by hunting for control tokens, then
// decodes each aligned word into video data or a control code.
//
// Ports:
//   clk     in   pixel clock
//   rst_n   in   asynchronous active-low reset
//   raw_in  in   [9:0] deserialized word, bit 0 is the earliest serial bit
//   vd      out  [7:0] decoded video data (valid when vde=1)
//   cd      out  [1:0] decoded control code (valid when vde=0)
//   vde     out  1 = vd valid, 0 = cd valid
//   locked  out  word alignment locked
//   offset  out  [3:0] current bit offset, 0..9
//
// raw_in reaches vd/cd/vde two clocks later: raw_in -> prev_raw_p0 ->
// aligned_p1, and the decode of aligned_p1 drives the outputs directly.
module tmds_decoder #(
    parameter int LOCK_RUN       = 8,
    parameter int SEARCH_TIMEOUT = 1024,
    parameter int LOSS_TIMEOUT   = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] raw_in,
    output logic [7:0] vd,
    output logic [1:0] cd,
    output logic       vde,
    output logic       locked,
    output logic [3:0] offset
);

    localparam logic [15:0] RUN_LAST    = 16'(LOCK_RUN - 1);
    localparam logic [15:0] SEARCH_LAST = 16'(SEARCH_TIMEOUT - 1);
    localparam logic [15:0] LOSS_LAST   = 16'(LOSS_TIMEOUT - 1);

    typedef enum logic [1:0] {SEARCH, SKIP, LOCKED} state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Returns {hit, code}.
    function automatic logic [2:0] token_lookup(input logic [9:0] w);
        case (w)
            10'b1101010100: return 3'b100;
            10'b0010101011: return 3'b101;
            10'b0101010100: return 3'b110;
            10'b1010101011: return 3'b111;
            default:        return 3'b000;
        endcase
    endfunction

    function automatic logic [7:0] data_decode(input logic [9:0] w);
        logic [7:0] q;
        logic [7:0] d;
        q    = w[9] ? ~w[7:0] : w[7:0];
        d[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = w[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
        return d;
    endfunction

    logic [9:0]  prev_raw_p0;
    logic        vld_p0;
    logic [9:0]  aligned_p1;
    logic        vld_p1;
    logic [7:0]  vd_hold;
    logic [1:0]  cd_hold;

    state_t      state_q, state_d;
    logic [3:0]  offset_q, offset_d;
    logic [15:0] run_q, run_d;
    logic [15:0] timer_q, timer_d;
    logic [15:0] loss_q, loss_d;

    logic [19:0] window;
    logic [2:0]  tok_info;
    logic [7:0]  dec_data;
    logic        tok;
    logic        data_now;

    assign window   = {raw_in, prev_raw_p0};
    assign tok_info = token_lookup(aligned_p1);
    assign dec_data = data_decode(aligned_p1);
    assign tok      = vld_p1 & tok_info[2];
    assign data_now = vld_p1 & ~tok_info[2];

    // Stage p0: previous raw word; stage p1: window at current offset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_raw_p0 <= '0;
            vld_p0      <= 1'b0;
            aligned_p1  <= '0;
            vld_p1      <= 1'b0;
            vd_hold     <= '0;
            cd_hold     <= '0;
        end else begin
            prev_raw_p0 <= raw_in;
            vld_p0      <= 1'b1;
            aligned_p1  <= 10'(window >> offset_q);
            vld_p1      <= vld_p0;
            if (tok) begin
                cd_hold <= tok_info[1:0];
            end else if (data_now) begin
                vd_hold <= dec_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= SEARCH;
            offset_q <= '0;
            run_q    <= '0;
            timer_q  <= '0;
            loss_q   <= '0;
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
            run_q    <= run_d;
            timer_q  <= timer_d;
            loss_q   <= loss_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        run_d    = run_q;
        timer_d  = timer_q;
        loss_d   = loss_q;
        case (state_q)
            SEARCH: begin
                run_d   = tok ? sat_inc(run_q) : '0;
                timer_d = sat_inc(timer_q);
                // Lock takes priority over a coincident timeout.
                if (tok && run_q == RUN_LAST) begin
                    state_d = LOCKED;
                    run_d   = '0;
                    timer_d = '0;
                    loss_d  = '0;
                end else if (timer_q == SEARCH_LAST) begin
                    state_d  = SKIP;
                    offset_d = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
                    run_d    = '0;
                    timer_d  = '0;
                end
            end
            // aligned_p1 still holds a word taken at the old offset.
            SKIP: state_d = SEARCH;
            LOCKED: begin
                if (tok) begin
                    loss_d = '0;
                end else if (loss_q == LOSS_LAST) begin
                    state_d = SEARCH;
                    loss_d  = '0;
                    run_d   = '0;
                    timer_d = '0;
                end else begin
                    loss_d = sat_inc(loss_q);
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    assign locked = (state_q == LOCKED);
    assign offset = offset_q;

    always_comb begin
        vde = locked & data_now;
        vd  = data_now ? dec_data : vd_hold;
        cd  = '0;
        if (locked) begin
            cd = tok ? tok_info[1:0] : cd_hold;
        end
    end

endmodule

// File: tb/tb_tmds_decoder.sv
module tb_tmds_decoder;

    localparam int LR = 8;
    localparam int ST = 16;
    localparam int LT = 32;

    localparam int M_SEARCH = 0;
    localparam int M_SKIP   = 1;
    localparam int M_LOCK   = 2;

    localparam logic [9:0] TOK0    = 10'b1101010100;
    localparam logic [9:0] TOK3    = 10'b1010101011;
    localparam logic [9:0] DATA_00 = 10'b0100000000;
    localparam logic [9:0] DATA_FE = 10'b1011111111;

    logic       clk;
    logic       rst_n;
    logic [9:0] raw_in;
    logic [7:0] vd;
    logic [1:0] cd;
    logic       vde;
    logic       locked;
    logic [3:0] offset;

    int n_checks;
    int n_errors;
    bit cmp_en;

    tmds_decoder #(
        .LOCK_RUN      (LR),
        .SEARCH_TIMEOUT(ST),
        .LOSS_TIMEOUT  (LT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .raw_in(raw_in),
        .vd    (vd),
        .cd    (cd),
        .vde   (vde),
        .locked(locked),
        .offset(offset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [9:0] prev;
        logic [9:0] al;
        bit         pv;
        bit         alv;
        int         off;
        int         mode;
        int         run;
        int         timer;
        int         quiet;
        logic [7:0] vd;
        logic [1:0] cd;
    } model_t;

    model_t m;

    function automatic logic [9:0] tok_word(input int code);
        case (code)
            0: return 10'b1101010100;
            1: return 10'b0010101011;
            2: return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    function automatic int tok_code(input logic [9:0] w);
        for (int c = 0; c < 4; c++) begin
            if (w == tok_word(c)) return c;
        end
        return -1;
    endfunction

    function automatic logic [7:0] dec(input logic [9:0] w);
        logic [7:0] q;
        logic [7:0] d;
        q = w[9] ? ~w[7:0] : w[7:0];
        d = q ^ {q[6:0], 1'b0};
        if (!w[8]) d = d ^ 8'hFE;
        return d;
    endfunction

    function automatic model_t model_reset();
        model_t r;
        r.prev = '0; r.al = '0; r.pv = 0; r.alv = 0;
        r.off = 0; r.mode = M_SEARCH; r.run = 0; r.timer = 0; r.quiet = 0;
        r.vd = '0; r.cd = '0;
        return r;
    endfunction

    function automatic model_t model_next(input model_t cur, input logic [9:0] raw);
        model_t n;
        int c;
        bit t;
        n = cur;
        c = cur.alv ? tok_code(cur.al) : -1;
        t = (c >= 0);
        if (cur.alv) begin
            if (t) n.cd = 2'(c);
            else   n.vd = dec(cur.al);
        end
        n.al   = 10'({raw, cur.prev} >> cur.off);
        n.alv  = cur.pv;
        n.prev = raw;
        n.pv   = 1;
        case (cur.mode)
            M_SEARCH: begin
                if (t && cur.run + 1 >= LR) begin
                    n.mode = M_LOCK; n.run = 0; n.timer = 0; n.quiet = 0;
                end else if (cur.timer + 1 >= ST) begin
                    n.off = (cur.off + 1) % 10; n.mode = M_SKIP; n.run = 0; n.timer = 0;
                end else begin
                    n.run = t ? cur.run + 1 : 0;
                    n.timer = cur.timer + 1;
                end
            end
            M_SKIP: n.mode = M_SEARCH;
            default: begin
                if (t) n.quiet = 0;
                else if (cur.quiet + 1 >= LT) begin
                    n.mode = M_SEARCH; n.quiet = 0; n.run = 0; n.timer = 0;
                end else n.quiet = cur.quiet + 1;
            end
        endcase
        return n;
    endfunction

    function automatic int exp_locked(input model_t x);
        return (x.mode == M_LOCK) ? 1 : 0;
    endfunction
    function automatic int exp_vde(input model_t x);
        return (x.mode == M_LOCK && x.alv && tok_code(x.al) < 0) ? 1 : 0;
    endfunction
    function automatic int exp_vd(input model_t x);
        return (x.alv && tok_code(x.al) < 0) ? int'(dec(x.al)) : int'(x.vd);
    endfunction
    function automatic int exp_cd(input model_t x);
        if (x.mode != M_LOCK) return 0;
        return (x.alv && tok_code(x.al) >= 0) ? tok_code(x.al) : int'(x.cd);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= model_reset();
        else        m <= model_next(m, raw_in);
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_vd",     int'(vd),     exp_vd(m));
            chk("model_cd",     int'(cd),     exp_cd(m));
            chk("model_vde",    int'(vde),    exp_vde(m));
            chk("model_locked", int'(locked), exp_locked(m));
            chk("model_offset", int'(offset), m.off);
        end
    end

    task automatic step(input logic [9:0] w);
        @(posedge clk);
        #1 raw_in = w;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_vd"},     int'(vd),     0);
        chk({nm, "_cd"},     int'(cd),     0);
        chk({nm, "_vde"},    int'(vde),    0);
        chk({nm, "_locked"}, int'(locked), 0);
        chk({nm, "_offset"}, int'(offset), 0);
    endtask

    initial begin
        logic [9:0] rot3;
        logic [9:0] sym;
        logic [9:0] psym;
        int s;
        int cnt;
        n_checks = 0;
        n_errors = 0;
        cmp_en   = 1'b0;
        raw_in   = '0;
        rst_n    = 1'b0;

        // Model pins against hand-computed values.
        chk("pin_dec_00", int'(dec(DATA_00)), 8'h00);
        chk("pin_dec_fe", int'(dec(DATA_FE)), 8'hFE);
        chk("pin_tok_11", tok_code(TOK3), 3);
        chk("pin_tok_01", tok_code(10'b0010101011), 1);
        chk("pin_notok",  tok_code(DATA_00), -1);

        cmp_en = 1'b1;
        repeat (3) @(posedge clk);
        #2 chk_all_zero("reset");

        // Aligned blanking: token present from cycle 0 after release.
        raw_in = TOK0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 9)  chk("lock_c9", int'(locked), 0);
            if (k == 10) begin
                chk("lock_c10", int'(locked), 1);
                chk("lock_cd",  int'(cd),     0);
                chk("lock_vde", int'(vde),    0);
            end
        end

        // Data decode while locked, two-cycle latency.
        step(DATA_00);
        step(DATA_FE);
        step(TOK3);
        @(negedge clk);
        chk("dec00_vd",  int'(vd),  8'h00);
        chk("dec00_vde", int'(vde), 1);
        step(TOK0);
        @(negedge clk);
        chk("decfe_vd",  int'(vd),  8'hFE);
        chk("decfe_vde", int'(vde), 1);
        step(TOK0);
        @(negedge clk);
        chk("tok11_cd",  int'(cd),  3);
        chk("tok11_vde", int'(vde), 0);
        chk("tok11_vd",  int'(vd),  8'hFE);

        // Loss of lock: last token on aligned word in cycle 17.
        for (int k = 16; k <= 50; k++) begin
            step(DATA_00);
            @(negedge clk);
            if (k == 49) chk("loss_held_c49", int'(locked), 1);
            if (k == 50) chk("loss_drop_c50", int'(locked), 0);
        end

        // Relock, then one token as the 31st word keeps lock.
        for (int k = 51; k <= 64; k++) step(TOK0);
        @(negedge clk);
        chk("relock", int'(locked), 1);
        for (int j = 1; j <= 51; j++) begin
            step((j == 31) ? TOK0 : ((j > 31) ? DATA_FE : DATA_00));
            @(negedge clk);
            chk("loss_token31_held", int'(locked), 1);
        end

        // Asynchronous reset mid-stream.
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        repeat (2) @(posedge clk);

        // Misaligned stream: tokens shifted by three bits.
        rot3   = {TOK3[6:0], TOK3[9:7]};
        raw_in = rot3;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk);
            @(negedge clk);
            case (k)
                15: chk("mis_off_c15", int'(offset), 0);
                16: chk("mis_off_c16", int'(offset), 1);
                32: chk("mis_off_c32", int'(offset), 1);
                33: chk("mis_off_c33", int'(offset), 2);
                49: chk("mis_off_c49", int'(offset), 2);
                50: chk("mis_off_c50", int'(offset), 3);
                58: chk("mis_lock_c58", int'(locked), 0);
                59: begin
                    chk("mis_lock_c59", int'(locked), 1);
                    chk("mis_lock_off", int'(offset), 3);
                end
                62: begin
                    chk("mis_cd",  int'(cd),  3);
                    chk("mis_vde", int'(vde), 0);
                end
                default: ;
            endcase
        end

        // Offset wrap with no tokens at all.
        rst_n  = 1'b0;
        raw_in = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 1; k <= 175; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("wrap_unlocked", int'(locked), 0);
            if (k >= 16 && (k - 16) % 17 == 0)
                chk("wrap_offset", int'(offset), ((k - 16) / 17 + 1) % 10);
        end

        // Randomised streams at random bit shifts.
        for (int seg = 0; seg < 6; seg++) begin
            s    = $urandom_range(0, 9);
            psym = '0;
            cnt  = 0;
            while (cnt < 500) begin
                for (int b = $urandom_range(4, 20); b > 0; b--) begin
                    sym  = tok_word($urandom_range(0, 3));
                    step(10'({sym, psym} >> (10 - s)));
                    psym = sym;
                    cnt++;
                end
                for (int b = $urandom_range(1, 45); b > 0; b--) begin
                    sym  = 10'($urandom_range(0, 1023));
                    step(10'({sym, psym} >> (10 - s)));
                    psym = sym;
                    cnt++;
                end
            end
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
